// File: rtl/axi_slice_dc_channel_writer.sv
// Write end of one dual-clock AXI slice channel: register buffer, Johnson-coded
// write token, and synchronized Johnson read pointer for occupancy tracking.
module axi_slice_dc_channel_writer #(
    parameter int DATA_WIDTH   = 64,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               isolate_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [DATA_WIDTH-1:0]              data_i,
    output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_o,
    output logic [BUFFER_WIDTH-1:0]            writetoken_o,
    input  logic [BUFFER_WIDTH-1:0]            readpointer_i,
    output logic [$clog2(BUFFER_WIDTH+1)-1:0]  fill_o,
    output logic                               empty_o,
    output logic                               full_o
);
    localparam int N  = BUFFER_WIDTH;
    localparam int KW = $clog2(2*N);
    localparam int SW = $clog2(N);
    localparam int FW = $clog2(N+1);
    localparam logic [KW:0]   TWO_N = (KW+1)'(2*N);
    localparam logic [KW-1:0] N_K   = KW'(N);

    // Position 0..2N-1 of a Johnson code: count of ones, mirrored once the
    // ones have started shifting out (LSB cleared).
    function automatic logic [KW-1:0] code_to_k(input logic [N-1:0] code);
        logic [KW:0] pc;
        pc = '0;
        for (int i = 0; i < N; i++) pc = pc + {{KW{1'b0}}, code[i]};
        if (code[0])
            return KW'(pc);
        else if (pc == '0)
            return '0;
        else
            return KW'(TWO_N - pc);
    endfunction

    function automatic logic [SW-1:0] k_to_slot(input logic [KW-1:0] k);
        return (k >= N_K) ? SW'(k - N_K) : SW'(k);
    endfunction

    function automatic logic [FW-1:0] fill_of(input logic [KW-1:0] kw,
                                              input logic [KW-1:0] kr);
        logic [KW:0] d;
        if (kw >= kr)
            d = {1'b0, kw} - {1'b0, kr};
        else
            d = {1'b0, kw} + TWO_N - {1'b0, kr};
        return FW'(d);
    endfunction

    logic [N-1:0]            r_wr_tok;
    logic [N-1:0]            r_sync [SYNC_STAGES];
    logic [N*DATA_WIDTH-1:0] r_data;

    logic [N-1:0]  w_rd_sync;
    logic [KW-1:0] w_k_wr;
    logic [KW-1:0] w_k_rd;
    logic [SW-1:0] w_slot;
    logic          w_push;

    assign w_rd_sync = r_sync[SYNC_STAGES-1];
    assign w_k_wr    = code_to_k(r_wr_tok);
    assign w_k_rd    = code_to_k(w_rd_sync);
    assign w_slot    = k_to_slot(w_k_wr);

    // Status depends only on registered state, never on valid_i/data_i.
    assign full_o   = (r_wr_tok == ~w_rd_sync);
    assign empty_o  = (r_wr_tok == w_rd_sync);
    assign fill_o   = fill_of(w_k_wr, w_k_rd);
    assign ready_o  = ~full_o & ~isolate_i;
    assign w_push   = valid_i & ready_o;

    assign writetoken_o = r_wr_tok;
    assign data_async_o = r_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= readpointer_i;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_tok <= '0;
            r_data   <= '0;
        end else if (w_push) begin
            for (int s = 0; s < N; s++) begin
                if (w_slot == SW'(s))
                    r_data[s*DATA_WIDTH +: DATA_WIDTH] <= data_i;
            end
            r_wr_tok <= {r_wr_tok[N-2:0], ~r_wr_tok[N-1]};
        end
    end

endmodule

// File: doc/axi_slice_dc_channel_writer.md
Name: axi_slice_dc_channel_writer

Overview:
- Write (transmitter) end of one channel of the dual-clock AXI slice.
- Runs in the source clock domain and accepts a valid/ready stream into a BUFFER_WIDTH-entry register buffer.
- Publishes the buffer contents and a Johnson-coded write token to the async interface (the aw/ar/w/r/b writetoken and data fields). It consumes the reader's Johnson-coded readpointer.
- Instantiated once per AXI channel inside the slave-side and master-side slice wrappers.

Parameters:
- DATA_WIDTH, 64, payload bits per entry (packed channel fields).
- BUFFER_WIDTH, 8, number of buffer entries and width of the token/pointer code; minimum 2.
- SYNC_STAGES, 2, flops in the readpointer synchronizer; minimum 2.

Ports:
- clk_i  in  1  source-domain clock.
- rst_i  in  1  synchronous reset, active-high.
- isolate_i  in  1  block new acceptances; buffered entries remain readable.
- valid_i  in  1  upstream payload valid.
- ready_o  out  1  upstream ready.
- data_i  in  DATA_WIDTH  upstream payload.
- data_async_o  out  BUFFER_WIDTH*DATA_WIDTH  all buffer entries; entry s at bits [s*DATA_WIDTH +: DATA_WIDTH].
- writetoken_o  out  BUFFER_WIDTH  Johnson-coded write pointer toward the reader.
- readpointer_i  in  BUFFER_WIDTH  Johnson-coded read pointer from the reader, asynchronous to clk_i.
- fill_o  out  $clog2(BUFFER_WIDTH+1)  occupancy as seen locally.
- empty_o  out  1  fill_o == 0.
- full_o  out  1  fill_o == BUFFER_WIDTH.

Behaviour:
- Johnson code, N = BUFFER_WIDTH:
  - Reset code is 0.
  - Advance rule: next = {code[N-2:0], ~code[N-1]}.
  - 2N states; exactly one bit changes per step, so the code is safe to synchronize.
- Code-to-index decode:
  - If code[0] == 1, k = popcount(code).
  - Otherwise k = (2N - popcount(code)) mod 2N.
  - Slot = k mod N.
- Synchronizer: readpointer_i passes through SYNC_STAGES flops, all reset to 0; the last stage is rd_sync.
- Status (combinational from registers only; independent of valid_i and data_i):
  - full_o = (wr_tok == ~rd_sync).
  - empty_o = (wr_tok == rd_sync).
  - fill_o = (k(wr_tok) - k(rd_sync)) mod 2N; always 0..N.
- ready_o = ~full_o & ~isolate_i. Combinational path isolate_i -> ready_o is allowed; no path from valid_i.
- Write on a clock edge with valid_i & ready_o:
  - data_i is stored to slot(wr_tok).
  - wr_tok advances on the same edge.
  - Other slots are unchanged.
- Slot contents hold until overwritten. A slot is never overwritten while it lies between rd_sync and wr_tok.
- writetoken_o is driven directly from the wr_tok flops, with no logic after them, so it is glitch-free.
- Write latency: entry data and the token become visible on data_async_o and writetoken_o 1 cycle after acceptance.
- Read-release latency: a reader advance is reflected in full_o, fill_o and ready_o SYNC_STAGES cycles after it appears on readpointer_i. Occupancy is therefore pessimistic, never optimistic.
- Wrap-around: k wraps from 2N-1 to 0 with no special handling; slot wraps from N-1 to 0.
- Isolate:
  - Asserting isolate_i drops ready_o in the same cycle. An upstream valid_i is held, not lost.
  - Already buffered entries drain normally and empty_o rises once the reader has caught up.
  - Deasserting isolate_i resumes acceptance in the same cycle if not full.
- Reset (rst_i high at a clock edge):
  - wr_tok = 0, all synchronizer flops = 0, all slots = 0.
  - ready_o = ~isolate_i, fill_o = 0, empty_o = 1, full_o = 0.
- Reset mid-operation discards all buffered entries. The reader must be reset in the same reset window; the writer does not detect pointer mismatch.
- Simultaneous write and synchronized read release in one cycle: both take effect; fill_o is unchanged.
- No writes are accepted when full, so overflow is impossible.

Test Plan:
- Reset, then N=8 with readpointer_i held 0; push 8 words 0x10..0x17:
  - All 8 accepted back-to-back.
  - full_o=1 and ready_o=0 after the 8th.
  - writetoken_o = 8'hFF.
  - Slot s holds 0x10+s.
- From full, advance readpointer_i to 8'h01 (one entry read):
  - ready_o rises exactly 2 cycles later (SYNC_STAGES=2).
  - The next push 0x18 lands in slot 0.
  - writetoken_o = 8'hFE.
- Continuous stream of 40 words with a reader model advancing one step every 3 cycles:
  - No slot is overwritten before it is read.
  - The reader sees an in-order sequence and the token wraps through all 16 codes at least twice.
- isolate_i asserted with valid_i held high and fill_o=3:
  - ready_o=0 in the same cycle and no write occurs.
  - After the reader drains 3 entries, empty_o=1.
  - Deasserting isolate_i accepts the held word next edge.
- Write and read release in the same cycle at fill_o=4: fill_o stays 4.
- rst_i pulsed mid-stream at fill_o=5:
  - Next cycle writetoken_o=0, fill_o=0, empty_o=1, data_async_o=0.
  - Then normal operation resumes.
